branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 8; number of outstanding prediction entries; power of two, >= 2.
REQ-002 SHALL have parameter CNT_W, default 16; width of each statistics counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port pred_valid  input  1  predictor output is valid this cycle; enqueue request.
REQ-006 SHALL have port pred  input  1  predicted direction, 1 = taken.
REQ-007 SHALL have port res_valid  input  1  execute stage resolves the oldest outstanding branch this cycle.
REQ-008 SHALL have port res_taken  input  1  actual direction of the resolving branch.
REQ-009 SHALL have port flush  input  1  discard all outstanding entries.
REQ-010 SHALL have port upd_result  output  1  one-cycle pulse driving the predictor's result input.
REQ-011 SHALL have port upd_taken  output  1  actual direction accompanying upd_result.
REQ-012 SHALL have port mispredict  output  1  one-cycle pulse; the resolved branch was mispredicted.
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-016 SHALL have port overflow_err  output  1  sticky; an enqueue was dropped.
REQ-017 SHALL have port underflow_err  output  1  sticky; a resolve arrived with no entry.
REQ-018 SHALL have port branch_cnt  output  CNT_W  number of accepted resolves.
REQ-019 SHALL have port mispred_cnt  output  CNT_W  number of accepted mispredicted resolves.

Function
REQ-020 SHALL store entries in a circular FIFO with read and write pointers modulo DEPTH; pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 SHALL accept a resolve (res_accept) when res_valid is high and count > 0 at the clock edge; it SHALL pop the oldest entry.
REQ-022 SHALL accept an enqueue when pred_valid is high, flush is low, and either count < DEPTH or res_accept is high in the same cycle; it SHALL write pred at the write pointer.
REQ-023 SHALL, when enqueue and res_accept occur together, keep count unchanged and advance both pointers, including when full.
REQ-024 SHALL, on res_accept, register at the next edge: upd_result = 1, upd_taken = res_taken, and mispredict = (stored pred != res_taken); latency is exactly one cycle.
REQ-025 SHALL drive upd_result and mispredict low in every cycle that does not follow a res_accept; upd_taken SHALL hold its last value.
REQ-026 SHALL set overflow_err when pred_valid is high, flush is low, count == DEPTH, and res_accept is low; the entry SHALL be discarded.
REQ-027 SHALL set underflow_err when res_valid is high and count == 0; no update pulse SHALL be produced and the counters SHALL not change.
REQ-028 SHALL process a res_accept in a flush cycle normally (pulse and counters), then empty the FIFO: count = 0 and pointers equal after the edge.
REQ-029 SHALL ignore pred_valid in a flush cycle and SHALL NOT set overflow_err for it.
REQ-030 SHALL increment branch_cnt on each res_accept, and mispred_cnt on each mispredicted res_accept; both SHALL saturate at 2^CNT_W-1.
REQ-031 SHALL clear overflow_err and underflow_err only by reset.
REQ-032 SHALL derive full, empty and count from registered state only, with no combinational path from inputs.

Reset
REQ-033 SHALL, while rst is high and independent of clk, force count = 0, both pointers = 0, empty = 1, full = 0, upd_result = 0, upd_taken = 0, mispredict = 0, both error flags = 0, and both counters = 0.
REQ-034 SHALL abandon in-flight entries and pending pulses when rst asserts mid-operation; the first edge after rst deasserts SHALL behave as from empty.

Verification
REQ-035 Enqueue preds 1,0,1, then resolve taken 1,1,1 on consecutive cycles -> upd_result pulses 3 cycles starting one cycle after the first resolve; mispredict only on the 2nd; branch_cnt = 3, mispred_cnt = 1; empty = 1.
REQ-036 Enqueue DEPTH=8 entries, then a 9th with no resolve -> full = 1, count = 8, overflow_err = 1; the 9th entry is never resolved.
REQ-037 With the FIFO full, assert pred_valid and res_valid together for 20 cycles -> count stays 8, no overflow_err, pointers wrap, and update order matches enqueue order.
REQ-038 res_valid while empty -> underflow_err = 1, upd_result stays 0, and the counters are unchanged.
REQ-039 With 3 entries, assert flush together with res_valid (taken 0, pred 1) and pred_valid -> one mispredict pulse, count = 0 after the edge, and the new pred is not stored.
REQ-040 With CNT_W = 2, make 5 mispredicted resolves and then assert rst asynchronously between edges -> both counters saturate at 3, then all outputs go to their reset values immediately.

Source files
------------

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch prediction resolve queue with predictor update and statistics
// Holds predicted directions until execute resolves them in order.

module branch_resolver #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pred_valid,
   input  logic                     pred,
   input  logic                     res_valid,
   input  logic                     res_taken,
   input  logic                     flush,
   output logic                     upd_result,
   output logic                     upd_taken,
   output logic                     mispredict,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err,
   output logic                     underflow_err,
   output logic [CNT_W-1:0]         branch_cnt,
   output logic [CNT_W-1:0]         mispred_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] pred_mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             res_accept;
   logic             enq;
   logic             drop;
   logic             stored_pred;
   logic             miss;

   assign full        = (count == DEPTH_C);
   assign empty       = (count == '0);
   assign stored_pred = pred_mem[rd_ptr];
   assign res_accept  = res_valid && !empty;
   // A simultaneous pop frees a slot, so a full queue can still enqueue.
   assign enq         = pred_valid && !flush && (!full || res_accept);
   assign drop        = pred_valid && !flush && full && !res_accept;
   assign miss        = res_accept && (stored_pred != res_taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_mem      <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         upd_result    <= 1'b0;
         upd_taken     <= 1'b0;
         mispredict    <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
         branch_cnt    <= '0;
         mispred_cnt   <= '0;
      end else begin
         if (enq)
            pred_mem[wr_ptr] <= pred;

         // Power-of-two depth lets pointers wrap by natural overflow.
         if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (enq)
               wr_ptr <= wr_ptr + 1'b1;
            if (res_accept)
               rd_ptr <= rd_ptr + 1'b1;
            case ({enq, res_accept})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end

         upd_result <= res_accept;
         mispredict <= miss;
         if (res_accept)
            upd_taken <= res_taken;

         if (res_accept && (branch_cnt != '1))
            branch_cnt <= branch_cnt + 1'b1;
         if (miss && (mispred_cnt != '1))
            mispred_cnt <= mispred_cnt + 1'b1;

         if (drop)
            overflow_err <= 1'b1;
         if (res_valid && empty)
            underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed-vector bench for branch_resolver
// Runs with DEPTH 8 and 2-bit counters so saturation is reachable.

module tb_branch_resolver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pred_valid, pred, res_valid, res_taken, flush;
   logic       upd_result, upd_taken, mispredict, full, empty;
   logic [3:0] count;
   logic       overflow_err, underflow_err;
   logic [1:0] branch_cnt, mispred_cnt;

   int nvec  = 0;
   int nfail = 0;

   branch_resolver #(.DEPTH(8), .CNT_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pred_valid    (pred_valid),
      .pred          (pred),
      .res_valid     (res_valid),
      .res_taken     (res_taken),
      .flush         (flush),
      .upd_result    (upd_result),
      .upd_taken     (upd_taken),
      .mispredict    (mispredict),
      .full          (full),
      .empty         (empty),
      .count         (count),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err),
      .branch_cnt    (branch_cnt),
      .mispred_cnt   (mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pred_valid = 1'b0;
      pred       = 1'b0;
      res_valid  = 1'b0;
      res_taken  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"},   count,         0);
      chk({tag, "_empty"},   empty,         1);
      chk({tag, "_full"},    full,          0);
      chk({tag, "_upd"},     upd_result,    0);
      chk({tag, "_updtk"},   upd_taken,     0);
      chk({tag, "_misp"},    mispredict,    0);
      chk({tag, "_ovf"},     overflow_err,  0);
      chk({tag, "_unf"},     underflow_err, 0);
      chk({tag, "_bcnt"},    branch_cnt,    0);
      chk({tag, "_mcnt"},    mispred_cnt,   0);
   endtask

   logic       q[$];
   logic       exp_p;
   logic [7:0] pat;

   initial begin
      idle();
      #1 rst = 1'b1;
      #2 chk_reset_state("rst0");
      @(negedge clk);
      rst = 1'b0;

      // preds 1,0,1 resolved taken three times in a row
      pred_valid = 1'b1; pred = 1'b1; tick();
      pred = 1'b0; tick();
      pred = 1'b1; tick();
      chk("t1_count3", count, 3);
      pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
      tick(); chk("t1_upd0", upd_result, 1); chk("t1_misp0", mispredict, 0);
      tick(); chk("t1_upd1", upd_result, 1); chk("t1_misp1", mispredict, 1);
      tick(); chk("t1_upd2", upd_result, 1); chk("t1_misp2", mispredict, 0);
      res_valid = 1'b0;
      tick(); chk("t1_upd_end", upd_result, 0);
      chk("t1_bcnt", branch_cnt, 3);
      chk("t1_mcnt", mispred_cnt, 1);
      chk("t1_empty", empty, 1);
      chk("t1_updtk", upd_taken, 1);

      // fill to DEPTH then overflow with a 9th entry
      do_reset();
      pat = 8'b1011_0010;
      pred_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pred = pat[i];
         tick();
      end
      chk("t2_full", full, 1);
      chk("t2_ovf_pre", overflow_err, 0);
      pred = 1'b0; tick();
      chk("t2_count8", count, 8);
      chk("t2_ovf", overflow_err, 1);
      pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("t2_misp%0d", i), mispredict, !pat[i]);
      end
      res_valid = 1'b0; tick();
      chk("t2_empty", empty, 1);
      chk("t2_ovf_sticky", overflow_err, 1);
      chk("t2_unf", underflow_err, 0);

      // full queue, simultaneous enqueue and resolve for 20 cycles
      do_reset();
      q.delete();
      pred_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pred = ((i % 3) == 1);
         q.push_back(pred);
         tick();
      end
      res_valid = 1'b1; res_taken = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pred  = ((i % 4) == 0);
         exp_p = q.pop_front();
         q.push_back(pred);
         tick();
         chk($sformatf("t3_upd%0d", i), upd_result, 1);
         chk($sformatf("t3_misp%0d", i), mispredict, !exp_p);
         chk($sformatf("t3_count%0d", i), count, 8);
      end
      idle(); tick();
      chk("t3_ovf", overflow_err, 0);
      chk("t3_bcnt_sat", branch_cnt, 3);
      chk("t3_mcnt_sat", mispred_cnt, 3);

      // resolve with nothing outstanding
      do_reset();
      res_valid = 1'b1; res_taken = 1'b1; tick();
      chk("t4_unf", underflow_err, 1);
      chk("t4_upd", upd_result, 0);
      chk("t4_bcnt", branch_cnt, 0);
      chk("t4_updtk", upd_taken, 0);
      idle(); tick();
      chk("t4_unf_sticky", underflow_err, 1);

      // flush coinciding with a mispredicted resolve and an enqueue
      do_reset();
      pred_valid = 1'b1; pred = 1'b1;
      tick(); tick(); tick();
      chk("t5_count3", count, 3);
      flush = 1'b1; res_valid = 1'b1; res_taken = 1'b0; pred = 1'b0;
      tick();
      chk("t5_upd", upd_result, 1);
      chk("t5_misp", mispredict, 1);
      chk("t5_count0", count, 0);
      chk("t5_empty", empty, 1);
      chk("t5_ovf", overflow_err, 0);
      chk("t5_mcnt", mispred_cnt, 1);
      idle(); res_valid = 1'b1; res_taken = 1'b1; tick();
      chk("t5_unf", underflow_err, 1);
      chk("t5_upd_none", upd_result, 0);

      // counter saturation then asynchronous reset between edges
      do_reset();
      pred_valid = 1'b1; pred = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t6_bcnt_sat", branch_cnt, 3);
      chk("t6_mcnt_sat", mispred_cnt, 3);
      tick();
      chk("t6_unf", underflow_err, 1);
      chk("t6_updtk", upd_taken, 1);
      idle();
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_reset_state("t6_async");
      @(negedge clk);
      rst = 1'b0;
      pred_valid = 1'b1; pred = 1'b1; tick();
      chk("t6_post_count", count, 1);
      idle(); res_valid = 1'b1; res_taken = 1'b1; tick();
      chk("t6_post_upd", upd_result, 1);
      chk("t6_post_misp", mispredict, 0);
      chk("t6_post_bcnt", branch_cnt, 1);
      idle(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
